// File: rtl/chip8_fetch.sv
// -----------------------------------------------------------------------------
// chip8_fetch
//   Instruction fetch stage of the CHIP-8 core. It reads the two bytes of each
//   16-bit big-endian opcode from byte-wide program memory at the current PC.
//   It pulses the PC increment strobe once per byte. It then holds the assembled
//   opcode on a valid/ready handshake until the executor consumes it.
//
// Parameters
//   READ_LATENCY   cycles from mem_rd_en_o/mem_addr_o to mem_rdata_i valid (1..4)
//
// Ports
//   clk_i           system clock, rising edge
//   rst_n_i         synchronous reset, active-low
//   run_i           1 = fetch enabled, 0 = halt at the next opcode boundary
//   pc_in_i         current PC (byte address)
//   pc_inc_stb_o    one-cycle pulse: PC += 1
//   mem_rd_en_o     program memory read enable
//   mem_addr_o      program memory byte address
//   mem_rdata_i     program memory read data
//   instr_o         fetched opcode {hi_byte, lo_byte}
//   instr_valid_o   instr_o holds a complete, stable opcode
//   instr_ready_i   executor done with instr_o
//   fetch_busy_o    1 in every state except IDLE and VALID
//   dbg_state_o     current FSM state encoding
//
// Handshake: an opcode is transferred on every rising edge where
//   instr_valid_o=1 and instr_ready_i=1. Once instr_valid_o is raised, it stays
//   high and instr_o stays constant until that transfer. instr_ready_i has no
//   effect while instr_valid_o=0.
// -----------------------------------------------------------------------------
module chip8_fetch #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        run_i,
    input  logic [11:0] pc_in_i,
    output logic        pc_inc_stb_o,
    output logic        mem_rd_en_o,
    output logic [11:0] mem_addr_o,
    input  logic [7:0]  mem_rdata_i,
    output logic [15:0] instr_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic        fetch_busy_o,
    output logic [2:0]  dbg_state_o
);

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("chip8_fetch: READ_LATENCY must be in 1..4");
    end

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH_HI = 3'd1,
        S_WAIT_HI  = 3'd2,
        S_FETCH_LO = 3'd3,
        S_WAIT_LO  = 3'd4,
        S_VALID    = 3'd5
    } state_e;

    localparam logic [1:0] LAST_WAIT = 2'(READ_LATENCY - 1);

    state_e      state_q, state_d;
    logic [1:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] instr_q, instr_d;
    logic        inc_stb;
    logic        wait_last;

    assign wait_last = (wait_cnt_q == LAST_WAIT);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 2'd0;
            instr_q    <= 16'h0000;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            instr_q    <= instr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        instr_d     = instr_q;
        inc_stb     = 1'b0;
        mem_rd_en_o = 1'b0;
        mem_addr_o  = 12'h000;

        case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    state_d = S_FETCH_HI;
                end
            end

            S_FETCH_HI: begin
                mem_rd_en_o = 1'b1;
                mem_addr_o  = pc_in_i;
                wait_cnt_d  = 2'd0;
                state_d     = S_WAIT_HI;
            end

            // The read data is valid in the last wait cycle. The byte is latched
            // there, and the PC is bumped in the same cycle, so FETCH_LO sees
            // the incremented PC on pc_in_i.
            S_WAIT_HI: begin
                if (wait_last) begin
                    instr_d[15:8] = mem_rdata_i;
                    inc_stb       = 1'b1;
                    state_d       = S_FETCH_LO;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end

            S_FETCH_LO: begin
                mem_rd_en_o = 1'b1;
                mem_addr_o  = pc_in_i;
                wait_cnt_d  = 2'd0;
                state_d     = S_WAIT_LO;
            end

            S_WAIT_LO: begin
                if (wait_last) begin
                    instr_d[7:0] = mem_rdata_i;
                    inc_stb      = 1'b1;
                    state_d      = S_VALID;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end

            // run_i is only looked at here and in IDLE. A halt request made
            // mid-fetch therefore still delivers the opcode that is in progress.
            S_VALID: begin
                if (instr_ready_i) begin
                    state_d = run_i ? S_FETCH_HI : S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A fetch aborted by reset must not bump the PC in the reset cycle itself.
    assign pc_inc_stb_o  = inc_stb & rst_n_i;
    assign instr_o       = instr_q;
    assign instr_valid_o = (state_q == S_VALID);
    assign fetch_busy_o  = (state_q != S_IDLE) && (state_q != S_VALID);
    assign dbg_state_o   = state_q;

endmodule
